// File: rtl/aes_inv_key_sched_pkg.sv
// Shared AES definitions for the inverse-cipher key schedule.
//   - mode encodings and per-mode Nk / Nr / Nw
//   - FSM state encoding
//   - byte-level helpers: S-box lookup, xtime, RotWord
package aes_inv_key_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;

    localparam int         WORDS_MAX = 60;
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Words in the cipher key.
    function automatic logic [5:0] mode_nk(input logic [1:0] m);
        case (m)
            MODE_192: return 6'd6;
            MODE_256: return 6'd8;
            default:  return 6'd4;
        endcase
    endfunction

    // Number of rounds (highest round-key index).
    function automatic logic [3:0] mode_nr(input logic [1:0] m);
        case (m)
            MODE_192: return 4'd12;
            MODE_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

    // Total words in the expanded schedule.
    function automatic logic [5:0] mode_nw(input logic [1:0] m);
        case (m)
            MODE_192: return 6'd52;
            MODE_256: return 6'd60;
            default:  return 6'd44;
        endcase
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bits [2047-8x -: 8]; 2047-8x == {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b111} -: 8];
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational.
//   word_in  [31:0] : input word
//   word_out [31:0] : byte-wise S-box substitution of word_in
module aes_subword
    import aes_inv_key_sched_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES key schedule with random-access round-key read port, intended to feed
// an inverse cipher (round keys read Nr down to 0, one per cycle).
//
// Build option: AES_KEY_ZEROIZE_EN -- when defined, the 60-word store is
// cleared asynchronously by reset and cleared again in every LOAD cycle.
// Without it the store has no reset and unused words keep stale contents.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   keygen     : one-cycle pulse, starts expansion of key_in with mode
//   key_in     : cipher key, MSB-aligned (w0 = key_in[255:224])
//   mode       : 00 AES-128, 01 AES-192, 10 AES-256, 11 invalid
//   rk_req     : round-key read strobe (honoured only when key_ready)
//   rk_idx     : round-key index 0..Nr
//   round_key  : registered round key {w[4k],..,w[4k+3]}
//   rk_valid   : round_key was updated by the read issued last cycle
//   busy       : loading or expanding
//   key_ready  : full schedule available
//   err        : sticky bad-mode / bad-index flag, cleared by a valid keygen
//
// Handshake: rk_req/rk_idx sampled at a clock edge while key_ready is high;
// the addressed key appears on round_key with rk_valid high in the following
// cycle. Requests every cycle are accepted back-to-back.
module aes_inv_key_sched
    import aes_inv_key_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         keygen,
    input  logic [255:0] key_in,
    input  logic [1:0]   mode,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic [127:0] round_key,
    output logic         rk_valid,
    output logic         busy,
    output logic         key_ready,
    output logic         err
);

    state_t      state, state_next;
    logic [1:0]  mode_q;
    logic [5:0]  nk, nw;
    logic [3:0]  nr;
    logic [5:0]  cnt;      // index of the word being generated
    logic [2:0]  phase;    // cnt mod Nk, tracked incrementally
    logic [7:0]  rcon;
    logic        keygen_ok;

    logic [31:0] w_mem [WORDS_MAX];

    logic [31:0] prev_word, old_word, sub_in, sub_out, temp_word, new_word;
    logic [5:0]  rk_base;

    assign keygen_ok = keygen && (mode != MODE_BAD);
    assign nk = mode_nk(mode_q);
    assign nr = mode_nr(mode_q);
    assign nw = mode_nw(mode_q);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (keygen) begin
            // A bad mode abandons any current schedule.
            state_next = keygen_ok ? ST_LOAD : ST_IDLE;
        end else begin
            case (state)
                ST_LOAD:   state_next = ST_EXPAND;
                ST_EXPAND: if (cnt == nw - 6'd1) state_next = ST_READY;
                default:   state_next = state;
            endcase
        end
    end

    always_comb begin
        busy      = (state == ST_LOAD) || (state == ST_EXPAND);
        key_ready = (state == ST_READY);
    end

    // ---------------- expansion datapath ----------------
    assign prev_word = w_mem[cnt - 6'd1];
    assign old_word  = w_mem[cnt - nk];
    assign sub_in    = (phase == 3'd0) ? rot_word(prev_word) : prev_word;

    aes_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        if (phase == 3'd0)
            temp_word = sub_out ^ {rcon, 24'h000000};
        else if ((nk == 6'd8) && (phase == 3'd4))
            temp_word = sub_out;
        else
            temp_word = prev_word;
        new_word = temp_word ^ old_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_128;
            cnt    <= '0;
            phase  <= '0;
            rcon   <= RCON_INIT;
        end else if (keygen) begin
            if (keygen_ok) mode_q <= mode;
        end else begin
            case (state)
                ST_LOAD: begin
                    cnt   <= nk;
                    phase <= '0;
                    rcon  <= RCON_INIT;
                end
                ST_EXPAND: begin
                    cnt   <= cnt + 6'd1;
                    phase <= ({3'b000, phase} == nk - 6'd1) ? 3'd0 : phase + 3'd1;
                    if (phase == 3'd0) rcon <= xtime(rcon);
                end
                default: ;
            endcase
        end
    end

    // ---------------- word store ----------------
`ifdef AES_KEY_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WORDS_MAX; k++) w_mem[k] <= '0;
        end else if (state == ST_LOAD) begin
            // Wipe the previous schedule; key words override below.
            for (int k = 0; k < WORDS_MAX; k++) w_mem[k] <= '0;
            for (int j = 0; j < 8; j++)
                if (6'(j) < nk) w_mem[j] <= key_in[255 - 32*j -: 32];
        end else if (state == ST_EXPAND) begin
            w_mem[cnt] <= new_word;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            for (int j = 0; j < 8; j++)
                if (6'(j) < nk) w_mem[j] <= key_in[255 - 32*j -: 32];
        end else if (state == ST_EXPAND) begin
            w_mem[cnt] <= new_word;
        end
    end
`endif

    // ---------------- round-key read port and error flag ----------------
    assign rk_base = {rk_idx, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_key <= '0;
            rk_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            if (rk_req && (state == ST_READY)) begin
                if (rk_idx <= nr) begin
                    round_key <= {w_mem[rk_base],         w_mem[rk_base + 6'd1],
                                  w_mem[rk_base + 6'd2],  w_mem[rk_base + 6'd3]};
                    rk_valid  <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
            // keygen wins: it either clears the flag or reports a bad mode.
            if (keygen) err <= (mode == MODE_BAD);
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] K128_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] K256_R0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] K256_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] K256_R3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;

    logic         clk;
    logic         rst_n;
    logic         keygen;
    logic [255:0] key_in;
    logic [1:0]   mode;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         rk_valid;
    logic         busy;
    logic         key_ready;
    logic         err;

    int total = 0;
    int bad   = 0;
    logic [127:0] last_rk;

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keygen    (keygen),
        .key_in    (key_in),
        .mode      (mode),
        .rk_req    (rk_req),
        .rk_idx    (rk_idx),
        .round_key (round_key),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .key_ready (key_ready),
        .err       (err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [255:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check_key(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [1:0] m);
        case (m)
            2'b01:   return 48;
            2'b10:   return 54;
            default: return 42;
        endcase
    endfunction

    // Pulse keygen; lat counts edges from the sampling edge (=1) until
    // key_ready is seen, bounded at 200.
    task automatic do_keygen(input logic [1:0] m, input logic [255:0] k, output int lat);
        keygen = 1'b1;
        mode   = m;
        key_in = k;
        @(posedge clk); #1;
        keygen = 1'b0;
        lat = 1;
        while (!key_ready && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pulse_keygen(input logic [1:0] m, input logic [255:0] k);
        keygen = 1'b1;
        mode   = m;
        key_in = k;
        @(posedge clk); #1;
        keygen = 1'b0;
    endtask

    task automatic read_key(input string name, input logic [3:0] idx, input logic [127:0] exp);
        rk_req = 1'b1;
        rk_idx = idx;
        @(posedge clk); #1;
        rk_req = 1'b0;
        check_bit({name, "_valid"}, rk_valid, 1'b1);
        check_key(name, round_key, exp);
        last_rk = exp;
    endtask

    initial begin
        int lat;
        int pulses;
        logic [1:0]   cur_mode;
        logic [255:0] cur_key;

        rst_n  = 1'b0;
        keygen = 1'b0;
        key_in = '0;
        mode   = 2'b00;
        rk_req = 1'b0;
        rk_idx = '0;
        last_rk = '0;

        vecs[0]  = '{2'b00, KEY128, 4'd0,  KEY128[255:128]};
        vecs[1]  = '{2'b00, KEY128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{2'b00, KEY128, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{2'b00, KEY128, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[4]  = '{2'b00, KEY128, 4'd10, K128_R10};
        vecs[5]  = '{2'b01, KEY192, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
        vecs[6]  = '{2'b01, KEY192, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[7]  = '{2'b01, KEY192, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[8]  = '{2'b10, KEY256, 4'd0,  K256_R0};
        vecs[9]  = '{2'b10, KEY256, 4'd2,  K256_R2};
        vecs[10] = '{2'b10, KEY256, 4'd3,  K256_R3};
        vecs[11] = '{2'b10, KEY256, 4'd14, K256_R14};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_key("rst_round_key", round_key, '0);
        check_bit("rst_rk_valid", rk_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_key_ready", key_ready, 1'b0);
        check_bit("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // table: new keygen whenever mode/key changes, then one read each
        cur_mode = 2'b11;
        cur_key  = '0;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].mode != cur_mode || vecs[i].key != cur_key) begin
                cur_mode = vecs[i].mode;
                cur_key  = vecs[i].key;
                do_keygen(cur_mode, cur_key, lat);
                check_int($sformatf("latency_vec%0d", i), lat, exp_latency(cur_mode));
                check_bit($sformatf("err_after_keygen_vec%0d", i), err, 1'b0);
            end
            read_key($sformatf("vec%0d", i), vecs[i].idx, vecs[i].exp);
        end

        // AES-256 decryption order: 14..0 back-to-back
        pulses = 0;
        rk_req = 1'b1;
        for (int k = 14; k >= 0; k--) begin
            rk_idx = 4'(k);
            @(posedge clk); #1;
            if (rk_valid) pulses++;
            case (k)
                14: check_key("burst_r14", round_key, K256_R14);
                3:  check_key("burst_r3", round_key, K256_R3);
                2:  check_key("burst_r2", round_key, K256_R2);
                1:  check_key("burst_r1", round_key, K256_R1);
                0:  check_key("burst_r0", round_key, K256_R0);
                default: ;
            endcase
        end
        rk_req = 1'b0;
        last_rk = K256_R0;
        check_int("burst_pulses", pulses, 15);
        @(posedge clk); #1;
        check_bit("burst_end_valid", rk_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_key("rk_stable", round_key, last_rk);

        // invalid mode
        pulse_keygen(2'b11, KEY128);
        check_bit("badmode_err", err, 1'b1);
        check_bit("badmode_busy", busy, 1'b0);
        check_bit("badmode_ready", key_ready, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_bit("badmode_idle_busy", busy, 1'b0);
        check_bit("badmode_idle_ready", key_ready, 1'b0);
        rk_req = 1'b1;
        rk_idx = 4'd0;
        @(posedge clk); #1;
        rk_req = 1'b0;
        check_bit("idle_req_valid", rk_valid, 1'b0);
        check_key("idle_req_hold", round_key, last_rk);

        // invalid index in AES-128
        do_keygen(2'b00, KEY128, lat);
        check_int("latency_128b", lat, 42);
        check_bit("err_cleared", err, 1'b0);
        rk_req = 1'b1;
        rk_idx = 4'd11;
        @(posedge clk); #1;
        rk_req = 1'b0;
        check_bit("badidx_valid", rk_valid, 1'b0);
        check_bit("badidx_err", err, 1'b1);
        check_key("badidx_hold", round_key, last_rk);
        read_key("after_badidx_r10", 4'd10, K128_R10);
        check_bit("err_sticky", err, 1'b1);

        // keygen re-issued mid-EXPAND
        pulse_keygen(2'b10, KEY256);
        repeat (10) @(posedge clk);
        #1;
        check_bit("midexp_busy", busy, 1'b1);
        check_bit("midexp_ready", key_ready, 1'b0);
        do_keygen(2'b00, KEY128, lat);
        check_int("restart_latency", lat, 42);
        read_key("restart_r10", 4'd10, K128_R10);
        read_key("restart_r0", 4'd0, KEY128[255:128]);

        // reset mid-EXPAND
        pulse_keygen(2'b00, KEY128);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_ready", key_ready, 1'b0);
        check_key("abort_round_key", round_key, '0);
        check_bit("abort_err", err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check_bit("abort_stays_idle", key_ready, 1'b0);
        do_keygen(2'b00, KEY128, lat);
        check_int("fresh_latency", lat, 42);
        read_key("fresh_r10", 4'd10, K128_R10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
